// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes and small bit helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_rx_state_e;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // xor_all is the XOR of data bits and the received parity bit
    function automatic logic parity_error(input logic [1:0] mode, input logic xor_all);
        logic err;
        case (mode)
            PARITY_EVEN: err = xor_all;
            PARITY_ODD:  err = ~xor_all;
            default:     err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous idle-high serial line plus a registered
// falling-edge pulse. Flops reset to 1 so reset release never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_sync,
    output logic fall
);

    logic [1:0] sync_r;
    logic       fall_r;

    // Synchroniser chain and edge-detect flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], rx_in};
            fall_r <= sync_r[1] & ~sync_r[0];
        end
    end

    assign rx_sync = sync_r[1];
    assign fall    = fall_r;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with false-start rejection and parity/frame error flags.
// Define UART_RX_MAJORITY_EN to decide each bit by a 3-sample majority around mid-bit.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 56,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 s_clk,
    input  logic                 s_rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 po_flag,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BAUD_W  = $clog2(CLK_DIV);
    localparam int BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BIT_W   = $clog2(BIT_MAX);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLK_DIV / 2);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [BAUD_W-1:0] BAUD_DECIDE = BAUD_W'(CLK_DIV / 2 + 1);
`else
    localparam logic [BAUD_W-1:0] BAUD_DECIDE = BAUD_W'(CLK_DIV / 2);
`endif
    localparam logic [BIT_W-1:0]  DATA_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST   = BIT_W'(STOP_BITS - 1);
    localparam logic [1:0]        PARITY_MODE = 2'(PARITY);

    uart_rx_state_e       state_r, state_s;
    logic [BAUD_W-1:0]    baud_cnt_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_bit_r;
    logic                 stop_err_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 po_flag_r;
    logic                 parity_err_r;
    logic                 frame_err_r;

    logic line_s;
    logic fall_s;
    logic bit_s;
    logic sample_s;
    logic wrap_s;
    logic load_s;
    logic shift_en_s;
    logic par_en_s;
    logic stop_en_s;
    logic baud_clr_s;
    logic bit_clr_s;
    logic bit_inc_s;

    uart_rx_sync u_sync (
        .clk     (s_clk),
        .rst_n   (s_rst_n),
        .rx_in   (uart_rx),
        .rx_sync (line_s),
        .fall    (fall_s)
    );

    assign sample_s = (baud_cnt_r == BAUD_DECIDE);
    assign wrap_s   = (baud_cnt_r == BAUD_LAST);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early_r;

    // Capture the two samples that precede the decision point
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            early_r <= 2'b00;
        end else if (baud_cnt_r == BAUD_MID - BAUD_W'(1) || baud_cnt_r == BAUD_MID) begin
            early_r <= {early_r[0], line_s};
        end else begin
            early_r <= early_r;
        end
    end

    assign bit_s = maj3({early_r, line_s});
`else
    assign bit_s = line_s;
`endif

    // FSM state register
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_s    = state_r;
        load_s     = 1'b0;
        shift_en_s = 1'b0;
        par_en_s   = 1'b0;
        stop_en_s  = 1'b0;
        baud_clr_s = 1'b0;
        bit_clr_s  = 1'b0;
        bit_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_s    = ST_START;
                    baud_clr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                // A high line at mid start bit was only a glitch
                if (sample_s && bit_s) begin
                    state_s = ST_IDLE;
                end else if (wrap_s) begin
                    state_s   = ST_DATA;
                    bit_clr_s = 1'b1;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                shift_en_s = sample_s;
                if (wrap_s) begin
                    if (bit_cnt_r == DATA_LAST) begin
                        bit_clr_s = 1'b1;
                        state_s   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_inc_s = 1'b1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                par_en_s = sample_s;
                if (wrap_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Leave at the last stop sample so a start edge at bit end is never missed
                if (sample_s) begin
                    stop_en_s = 1'b1;
                    if (bit_cnt_r == STOP_LAST) begin
                        load_s  = 1'b1;
                        state_s = bit_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        state_s = ST_STOP;
                    end
                end else if (wrap_s) begin
                    bit_inc_s = 1'b1;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (line_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BREAK;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Baud counter: runs 0..CLK_DIV-1 while a frame is in progress
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            baud_cnt_r <= '0;
        end else if (baud_clr_s || state_r == ST_IDLE || wrap_s) begin
            baud_cnt_r <= '0;
        end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
        end
    end

    // Bit counter shared by data and stop phases
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            bit_cnt_r <= '0;
        end else if (bit_clr_s || baud_clr_s) begin
            bit_cnt_r <= '0;
        end else if (bit_inc_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Data shift register (LSB first), parity bit and sticky stop-bit error
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            shift_r    <= '0;
            par_bit_r  <= 1'b0;
            stop_err_r <= 1'b0;
        end else begin
            if (shift_en_s) begin
                shift_r <= {bit_s, shift_r[DATA_BITS-1:1]};
            end else begin
                shift_r <= shift_r;
            end
            if (par_en_s) begin
                par_bit_r <= bit_s;
            end else begin
                par_bit_r <= par_bit_r;
            end
            if (baud_clr_s) begin
                stop_err_r <= 1'b0;
            end else if (stop_en_s && !bit_s) begin
                stop_err_r <= 1'b1;
            end else begin
                stop_err_r <= stop_err_r;
            end
        end
    end

    // Output registers, updated once per completed frame
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rx_data_r    <= '0;
            po_flag_r    <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            po_flag_r <= load_s;
            if (load_s) begin
                rx_data_r    <= shift_r;
                parity_err_r <= parity_error(PARITY_MODE, ^{shift_r, par_bit_r});
                frame_err_r  <= stop_err_r | ~bit_s;
            end else begin
                rx_data_r    <= rx_data_r;
                parity_err_r <= parity_err_r;
                frame_err_r  <= frame_err_r;
            end
        end
    end

    assign rx_data    = rx_data_r;
    assign po_flag    = po_flag_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three configurations, directed cases and random frames
// compared against an expected-frame queue built from the frame contents.
module tb_uart_rx_param;

    localparam int CLK_DIV = 56;

    typedef struct packed {
        logic [1:0] idx;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

    logic       s_clk = 1'b0;
    logic       s_rst_n;
    logic [2:0] line_v;
    logic [7:0] d0, d1;
    logic [4:0] d2;
    logic [2:0] pf, pe, fe, bz;

    frame_t exp_q[$];
    frame_t obs_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    always #10 s_clk = ~s_clk;

    uart_rx_param #(.CLK_DIV(CLK_DIV)) dut0 (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .uart_rx(line_v[0]), .rx_data(d0),
        .po_flag(pf[0]), .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]));

    uart_rx_param #(.CLK_DIV(CLK_DIV), .PARITY(2)) dut1 (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .uart_rx(line_v[1]), .rx_data(d1),
        .po_flag(pf[1]), .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]));

    uart_rx_param #(.CLK_DIV(CLK_DIV), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) dut2 (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .uart_rx(line_v[2]), .rx_data(d2),
        .po_flag(pf[2]), .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2]));

    // Record every delivered frame
    always @(negedge s_clk) begin
        if (pf[0]) obs_q.push_back(frame_t'{2'd0, {1'b0, d0}, pe[0], fe[0]});
        if (pf[1]) obs_q.push_back(frame_t'{2'd1, {1'b0, d1}, pe[1], fe[1]});
        if (pf[2]) obs_q.push_back(frame_t'{2'd2, {4'b0, d2}, pe[2], fe[2]});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic hold(input int idx, input logic v, input int cyc);
        line_v[idx] = v;
        repeat (cyc) @(negedge s_clk);
    endtask

    task automatic expect_frame(input int idx, input logic [8:0] data, input logic perr, input logic ferr);
        exp_q.push_back(frame_t'{2'(idx), data, perr, ferr});
    endtask

    // Serialise one frame; glitch_bit >= 0 inverts that data bit for one cycle at mid-bit
    task automatic send_frame(input int idx, input int dbits, input int par, input int sbits,
                              input logic [8:0] data, input bit bad_par, input logic [1:0] stops,
                              input int glitch_bit);
        int   ones;
        logic p;
        hold(idx, 1'b0, CLK_DIV);
        ones = 0;
        for (int i = 0; i < dbits; i++) begin
            ones += int'(data[i]);
            if (i == glitch_bit) begin
                hold(idx, data[i], 29);
                hold(idx, ~data[i], 1);
                hold(idx, data[i], CLK_DIV - 30);
            end else begin
                hold(idx, data[i], CLK_DIV);
            end
        end
        if (par != 0) begin
            p = (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            if (bad_par) p = ~p;
            hold(idx, p, CLK_DIV);
        end
        for (int s = 0; s < sbits; s++) hold(idx, stops[s], CLK_DIV);
    endtask

    task automatic rand_frame(input int idx);
        int         dbits, par, sbits, gap;
        logic [8:0] data;
        bit         bad;
        logic [1:0] stops;
        logic       ferr;
        dbits = (idx == 2) ? 5 : 8;
        par   = (idx == 0) ? 0 : ((idx == 1) ? 2 : 1);
        sbits = (idx == 2) ? 2 : 1;
        data  = 9'($urandom) & ((9'd1 << dbits) - 9'd1);
        bad   = (par != 0) && ($urandom_range(0, 3) == 0);
        stops = 2'b11;
        if ($urandom_range(0, 4) == 0) stops[$urandom_range(0, sbits - 1)] = 1'b0;
        ferr = (stops[0] == 1'b0) || (sbits == 2 && stops[1] == 1'b0);
        send_frame(idx, dbits, par, sbits, data, bad, stops, -1);
        expect_frame(idx, data, bad, ferr);
        gap = $urandom_range(0, 20);
        if (stops[sbits - 1] == 1'b0) gap = CLK_DIV;
        line_v[idx] = 1'b1;
        if (gap > 0) hold(idx, 1'b1, gap);
    endtask

    task automatic check_frames(input string tag);
        frame_t e, o;
        repeat (5) @(negedge s_clk);
        check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check_eq($sformatf("%s_dut%0d_idx", tag, e.idx), 32'(o.idx), 32'(e.idx));
            check_eq($sformatf("%s_dut%0d_data", tag, e.idx), 32'(o.data), 32'(e.data));
            check_eq($sformatf("%s_dut%0d_perr", tag, e.idx), 32'(o.perr), 32'(e.perr));
            check_eq($sformatf("%s_dut%0d_ferr", tag, e.idx), 32'(o.ferr), 32'(e.ferr));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        logic [7:0] bytes [4];
        logic [7:0] b81;
        bytes  = '{8'h55, 8'hA3, 8'h00, 8'hFF};
        b81    = 8'h81;
        s_rst_n = 1'b0;
        line_v  = 3'b111;
        repeat (3) @(negedge s_clk);
        check_eq("rst_data", {d0, d1, 3'b000, d2}, 32'h0);
        check_eq("rst_flags", {pf, pe, fe, bz}, 32'h0);
        s_rst_n = 1'b1;
        repeat (5) @(negedge s_clk);

        // Back-to-back 8N1 frames with zero idle time
        for (int i = 0; i < 4; i++) begin
            send_frame(0, 8, 0, 1, {1'b0, bytes[i]}, 1'b0, 2'b11, -1);
            expect_frame(0, {1'b0, bytes[i]}, 1'b0, 1'b0);
        end
        check_frames("b2b");
        check_eq("data_held", 32'(d0), 32'h0FF);

        // Even parity: correct then corrupted parity bit
        send_frame(1, 8, 2, 1, 9'h0A3, 1'b0, 2'b11, -1);
        expect_frame(1, 9'h0A3, 1'b0, 1'b0);
        hold(1, 1'b1, 10);
        send_frame(1, 8, 2, 1, 9'h0A3, 1'b1, 2'b11, -1);
        expect_frame(1, 9'h0A3, 1'b1, 1'b0);
        hold(1, 1'b1, 10);
        check_frames("parity");
        check_eq("perr_held", 32'(pe[1]), 32'h1);

        // Stop bit low, line held low: frame error then break until line returns
        send_frame(0, 8, 0, 1, 9'h03C, 1'b0, 2'b00, -1);
        expect_frame(0, 9'h03C, 1'b0, 1'b1);
        hold(0, 1'b0, 4 * CLK_DIV);
        check_eq("break_busy", 32'(bz[0]), 32'h1);
        hold(0, 1'b1, 6);
        check_eq("break_idle", 32'(bz[0]), 32'h0);
        check_frames("frame_err");
        check_eq("ferr_held", 32'(fe[0]), 32'h1);

        // False start: short low glitch on an idle line
        hold(0, 1'b0, 10);
        check_eq("glitch_busy", 32'(bz[0]), 32'h1);
        hold(0, 1'b1, 30);
        check_eq("glitch_idle", 32'(bz[0]), 32'h0);
        check_frames("glitch");

        // Asynchronous reset in the middle of data bit 4
        hold(0, 1'b0, CLK_DIV);
        for (int i = 0; i < 4; i++) hold(0, b81[i], CLK_DIV);
        hold(0, b81[4], 20);
        #3 s_rst_n = 1'b0;
        line_v[0] = 1'b1;
        #1;
        check_eq("midrst_out", {d0, pf[0], pe[0], fe[0], bz[0]}, 32'h0);
        @(negedge s_clk);
        s_rst_n = 1'b1;
        hold(0, 1'b1, CLK_DIV);
        send_frame(0, 8, 0, 1, {1'b0, b81}, 1'b0, 2'b11, -1);
        expect_frame(0, {1'b0, b81}, 1'b0, 1'b0);
        check_frames("after_rst");

        // One-cycle inverted glitch at the middle of bit 3 of 0x55
        send_frame(0, 8, 0, 1, 9'h055, 1'b0, 2'b11, 3);
`ifdef UART_RX_MAJORITY_EN
        expect_frame(0, 9'h055, 1'b0, 1'b0);
`else
        expect_frame(0, 9'h05D, 1'b0, 1'b0);
`endif
        hold(0, 1'b1, 10);
        check_frames("midbit_glitch");

        // Random frames across all three configurations
        for (int n = 0; n < 30; n++) rand_frame($urandom_range(0, 2));
        check_frames("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
